idiv_wb_ctrl: RTL

//  Issue/writeback controller on the requester side of the iterative integer divider.

---
 rtl/idiv_wb_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/idiv_wb_ctrl.sv
// Requester-side issue/writeback controller for the iterative integer divider.
// Holds one divide in flight, returns its result through the shared write port and flags hazards on its rd.
package idiv_wb_pkg;
    localparam int reg_data_width_gp = 32;
    localparam int reg_addr_width_gp = 5;

    typedef enum logic [1:0] {
        eDIV  = 2'd0,
        eDIVU = 2'd1,
        eREM  = 2'd2,
        eREMU = 2'd3
    } idiv_op_e;
endpackage

module idiv_wb_ctrl
    import idiv_wb_pkg::*;
#(
    parameter int data_width_p     = reg_data_width_gp,
    parameter int reg_addr_width_p = reg_addr_width_gp
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        v_i,
    output logic                        ready_o,
    input  logic [data_width_p-1:0]     rs1_i,
    input  logic [data_width_p-1:0]     rs2_i,
    input  logic [reg_addr_width_p-1:0] rd_i,
    input  idiv_op_e                    op_i,
    output logic                        div_v_o,
    output logic [data_width_p-1:0]     div_rs1_o,
    output logic [data_width_p-1:0]     div_rs2_o,
    output logic [reg_addr_width_p-1:0] div_rd_o,
    output idiv_op_e                    div_op_o,
    input  logic                        div_ready_and_i,
    input  logic                        div_v_i,
    input  logic [reg_addr_width_p-1:0] div_rd_i,
    input  logic [data_width_p-1:0]     div_result_i,
    output logic                        div_yumi_o,
    output logic                        rf_w_v_o,
    output logic [reg_addr_width_p-1:0] rf_w_addr_o,
    output logic [data_width_p-1:0]     rf_w_data_o,
    input  logic                        rf_w_grant_i,
    input  logic [reg_addr_width_p-1:0] haz_rs1_i,
    input  logic [reg_addr_width_p-1:0] haz_rs2_i,
    input  logic [reg_addr_width_p-1:0] haz_rd_i,
    output logic                        haz_stall_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        WB    = 2'd3
    } state_e;

    state_e                      state_q;
    logic [data_width_p-1:0]     rs1_q;
    logic [data_width_p-1:0]     rs2_q;
    logic [data_width_p-1:0]     result_q;
    logic [reg_addr_width_p-1:0] rd_q;
    idiv_op_e                    op_q;
    logic                        pending_q;
    logic                        ready_q;
    logic                        div_v_q;
    logic                        rf_w_v_q;

    logic                        accept_s;
    logic                        busy_s;
    logic                        capture_s;
    logic                        rd_zero_s;
    logic                        haz_match_s;

    // Handshake qualifiers; a result offered during reset is never consumed.
    always_comb begin
        accept_s  = v_i & ready_q;
        busy_s    = (state_q == BUSY);
        capture_s = busy_s & div_v_i & ~reset_i;
        rd_zero_s = (rd_q == {reg_addr_width_p{1'b0}});
    end

    // Decode conflicts with the in-flight rd; pending is never set for x0.
    always_comb begin
        haz_match_s = (haz_rs1_i == rd_q) | (haz_rs2_i == rd_q) | (haz_rd_i == rd_q);
    end

    // Controller FSM with latched request fields, captured result and registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            rs1_q     <= {data_width_p{1'b0}};
            rs2_q     <= {data_width_p{1'b0}};
            result_q  <= {data_width_p{1'b0}};
            rd_q      <= {reg_addr_width_p{1'b0}};
            op_q      <= eDIV;
            pending_q <= 1'b0;
            ready_q   <= 1'b1;
            div_v_q   <= 1'b0;
            rf_w_v_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        rs1_q     <= rs1_i;
                        rs2_q     <= rs2_i;
                        rd_q      <= rd_i;
                        op_q      <= op_i;
                        pending_q <= (rd_i != {reg_addr_width_p{1'b0}});
                        ready_q   <= 1'b0;
                        div_v_q   <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (div_ready_and_i) begin
                        div_v_q <= 1'b0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (capture_s) begin
                        result_q <= div_result_i;
                        if (rd_zero_s) begin
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            rf_w_v_q <= 1'b1;
                            state_q  <= WB;
                        end
                    end
                end
                WB: begin
                    // Write fields stay frozen until the pipeline yields the port.
                    if (rf_w_grant_i) begin
                        rf_w_v_q  <= 1'b0;
                        pending_q <= 1'b0;
                        ready_q   <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    pending_q <= 1'b0;
                    ready_q   <= 1'b1;
                    div_v_q   <= 1'b0;
                    rf_w_v_q  <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign ready_o     = ready_q;
    assign div_v_o     = div_v_q;
    assign div_rs1_o   = rs1_q;
    assign div_rs2_o   = rs2_q;
    assign div_rd_o    = rd_q;
    assign div_op_o    = op_q;
    assign div_yumi_o  = capture_s;
    assign rf_w_v_o    = rf_w_v_q;
    assign rf_w_addr_o = rd_q;
    assign rf_w_data_o = result_q;
    assign haz_stall_o = pending_q & haz_match_s;

    idiv_wb_ctrl_chk #(
        .reg_addr_width_p(reg_addr_width_p)
    ) u_chk (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .busy_i  (busy_s),
        .div_v_i (div_v_i),
        .div_rd_i(div_rd_i),
        .rd_i    (rd_q)
    );

endmodule

// Protocol checks on the divider response side of the controller.
module idiv_wb_ctrl_chk #(
    parameter int reg_addr_width_p = 5
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        busy_i,
    input  logic                        div_v_i,
    input  logic [reg_addr_width_p-1:0] div_rd_i,
    input  logic [reg_addr_width_p-1:0] rd_i
);

    a_result_only_when_busy: assert property (
        @(posedge clk_i) disable iff (reset_i) div_v_i |-> busy_i
    );

    a_result_rd_matches: assert property (
        @(posedge clk_i) disable iff (reset_i) (busy_i && div_v_i) |-> (div_rd_i == rd_i)
    );

endmodule
